// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity-mode constants
// and the default frame width.
package uart_pkg;

    localparam int DEFAULT_DATA_W = 8;

    localparam bit PARITY_MODE_EVEN = 1'b0;
    localparam bit PARITY_MODE_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_transmitter.sv
// UART transmit engine: captures a byte on wr_en and shifts it out LSB-first as
// start / data / optional parity / stop bits, advancing one bit per clken tick.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = PARITY_MODE_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              clken,
    output logic              tx,
    output logic              tx_busy
);

    localparam int              CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]        stop_cnt_q, stop_cnt_d;
    logic              par_q, par_d;
    logic              tx_q, tx_d;

    // NOTE: every _d gets a hold value first, so no path through the case leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;

        unique case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (wr_en) begin
                    shift_d    = din;
                    par_d      = PARITY_ODD;
                    bit_cnt_d  = '0;
                    stop_cnt_d = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (clken) begin
                    tx_d      = 1'b0;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end
            ST_DATA: begin
                // Parity accumulates from the captured bits as they leave the shifter.
                if (clken) begin
                    tx_d      = shift_q[0];
                    par_d     = par_q ^ shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        stop_cnt_d = '0;
                        state_d    = PARITY_EN ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (clken) begin
                    tx_d    = par_q;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (clken) begin
                    tx_d = 1'b1;
                    if (stop_cnt_q == LAST_STOP) begin
                        stop_cnt_d = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values computed above, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: three parameterisations share the
// stimulus; expected line bits are queued at write time and popped per baud tick.
module tb_uart_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic       clken;
    logic [7:0] din;
    logic [2:0] tx_w;
    logic [2:0] busy_w;

    always #5 clk = ~clk;

    uart_transmitter #(.DATA_W(8), .PARITY_EN(1'b0), .PARITY_ODD(1'b0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .clken(clken),
        .tx(tx_w[0]), .tx_busy(busy_w[0])
    );
    uart_transmitter #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b0), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .clken(clken),
        .tx(tx_w[1]), .tx_busy(busy_w[1])
    );
    uart_transmitter #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .clken(clken),
        .tx(tx_w[2]), .tx_busy(busy_w[2])
    );

    // Frame shape of each instance, as the bench knows it.
    int inst_stops[3]  = '{1, 2, 2};
    bit inst_paren[3]  = '{1'b0, 1'b1, 1'b1};

    int n_vec = 0;
    int n_err = 0;

    int div     = 1;
    int div_cnt = 0;
    bit was_tick;

    logic       exp_q[$];
    logic [1:0] bb_q[$];

    typedef struct {
        int         inst;
        logic [7:0] din;
        int         div;
        bit         disturb;
        logic       exp_par;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
        end
    endtask

    // One clock: remember whether this edge was a baud tick, then advance the divider.
    task automatic step();
        was_tick = clken;
        @(posedge clk);
        #1;
        if (div_cnt + 1 >= div) div_cnt = 0;
        else                    div_cnt++;
        clken = (div_cnt == div - 1);
    endtask

    task automatic set_div(input int d);
        div     = d;
        div_cnt = 0;
        clken   = (d == 1);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_frame(input int k, input logic [7:0] d, input logic p);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (inst_paren[k]) exp_q.push_back(p);
        for (int i = 0; i < inst_stops[k]; i++) exp_q.push_back(1'b1);
    endtask

    task automatic run_frame(input int k, input logic [7:0] d, input logic p,
                             input int dv, input bit disturb);
        int   idx;
        int   held;
        int   n;
        logic e;
        set_div(dv);
        din   = d;
        wr_en = 1'b1;
        push_frame(k, d, p);
        step();
        wr_en = 1'b0;
        check($sformatf("k%0d accept tx/busy", k), {busy_w[k], tx_w[k]}, 2'b11);
        n = 0;
        do begin
            step();
            n++;
        end while (!was_tick && n < dv + 4);
        if (!was_tick) begin
            check($sformatf("k%0d start tick timeout", k), was_tick, 1);
            exp_q.delete();
            return;
        end
        idx = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check($sformatf("k%0d d=%0h bit%0d busy/tx", k, d, idx),
                  {busy_w[k], tx_w[k]}, {1'b1, e});
            if (disturb && idx == 3) begin
                din   = 8'hFF;
                wr_en = 1'b1;
            end
            if (disturb && idx == 5) wr_en = 1'b0;
            held = 1;
            n    = 0;
            forever begin
                step();
                n++;
                if (was_tick || n > dv + 4) break;
                if (tx_w[k] === e && busy_w[k] === 1'b1) held++;
            end
            if (!was_tick) begin
                check($sformatf("k%0d bit%0d tick timeout", k, idx), was_tick, 1);
                exp_q.delete();
                return;
            end
            check($sformatf("k%0d d=%0h bit%0d hold clks", k, d, idx), held, dv);
            idx++;
        end
        check($sformatf("k%0d d=%0h frame end busy/tx", k, d), {busy_w[k], tx_w[k]}, 2'b01);
    endtask

    initial begin
        int tx_pat[12]   = '{1, 0, 1, 1, 0, 0, 0, 1, 1, 0, 1, 1};
        int busy_pat[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        logic [1:0] got;
        logic [1:0] want;

        vecs[0] = '{inst: 0, din: 8'h63, div: 1,  disturb: 1'b0, exp_par: 1'b0};
        vecs[1] = '{inst: 0, din: 8'hA5, div: 16, disturb: 1'b0, exp_par: 1'b0};
        vecs[2] = '{inst: 0, din: 8'h63, div: 4,  disturb: 1'b1, exp_par: 1'b0};
        vecs[3] = '{inst: 1, din: 8'h63, div: 1,  disturb: 1'b0, exp_par: 1'b0};
        vecs[4] = '{inst: 2, din: 8'h63, div: 1,  disturb: 1'b0, exp_par: 1'b1};
        vecs[5] = '{inst: 1, din: 8'hA5, div: 3,  disturb: 1'b0, exp_par: 1'b0};
        vecs[6] = '{inst: 2, din: 8'h01, div: 2,  disturb: 1'b0, exp_par: 1'b0};
        vecs[7] = '{inst: 1, din: 8'h01, div: 1,  disturb: 1'b0, exp_par: 1'b1};
        vecs[8] = '{inst: 2, din: 8'h63, div: 1,  disturb: 1'b1, exp_par: 1'b1};

        rst   = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;
        set_div(1);

        // Reset state, then idle line with no writes.
        do_reset();
        for (int k = 0; k < 3; k++)
            check($sformatf("k%0d reset busy/tx", k), {busy_w[k], tx_w[k]}, 2'b01);
        repeat (5) step();
        for (int k = 0; k < 3; k++)
            check($sformatf("k%0d idle busy/tx", k), {busy_w[k], tx_w[k]}, 2'b01);

        // Back-to-back 8'h63 frames with wr_en and clken held high: 12-clk period.
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 12; i++)
                bb_q.push_back({busy_pat[i][0], tx_pat[i][0]});
        din   = 8'h63;
        wr_en = 1'b1;
        for (int c = 0; c < 36; c++) begin
            step();
            got  = {busy_w[0], tx_w[0]};
            want = bb_q.pop_front();
            check($sformatf("b2b clk%0d busy/tx", c), got, want);
        end
        wr_en = 1'b0;

        for (int v = 0; v < 9; v++) begin
            do_reset();
            run_frame(vecs[v].inst, vecs[v].din, vecs[v].exp_par, vecs[v].div, vecs[v].disturb);
        end

        // Reset while the line is low in the data phase, then a clean frame.
        do_reset();
        set_div(1);
        din   = 8'h63;
        wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        repeat (4) step();
        check("pre-reset busy/tx", {busy_w[0], tx_w[0]}, 2'b10);
        rst = 1'b1;
        step();
        check("mid-frame reset busy/tx", {busy_w[0], tx_w[0]}, 2'b01);
        rst = 1'b0;
        step();
        check("post-reset idle busy/tx", {busy_w[0], tx_w[0]}, 2'b01);
        run_frame(0, 8'hA5, 1'b0, 1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
